// File: rtl/shift_pkg.sv
// Shared constants for the shift sequencer: barrel shift-type codes and FSM state encoding.
package shift_pkg;

  localparam logic [1:0] SC_LSL = 2'd0;
  localparam logic [1:0] SC_LSR = 2'd1;
  localparam logic [1:0] SC_ASR = 2'd2;
  localparam logic [1:0] SC_ROR = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Command queue: DEPTH entries of {data, sc, amt}, wrap-around pointers, occupancy count.
module shift_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH+4:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH+4:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 5;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Guard internally so a misbehaving caller can never overrun or underrun the queue.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequences queued shift commands into a barrel register stage one at a time and
// holds each returned result until the downstream consumer accepts it.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int RES_LAT = 1
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_data,
  input  logic [1:0]             cmd_sc,
  input  logic [2:0]             cmd_amt,
  output logic                   load,
  output logic [WIDTH-1:0]       data_out,
  output logic [1:0]             sc,
  output logic [2:0]             amt,
  input  logic [WIDTH-1:0]       r_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sc_q, sc_d;
  logic [2:0]       amt_q, amt_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             push, pop, full, empty;
  logic [WIDTH+4:0] head;

  // cmd_ready is gated by clear so it reads 0 for the whole reset interval.
  assign cmd_ready = !clear && !full;
  assign push      = cmd_valid && cmd_ready;

  shift_cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .clear     (clear),
    .push      (push),
    .push_data ({cmd_data, cmd_sc, cmd_amt}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sc_d        = sc_q;
    amt_d       = amt_q;
    wcnt_d      = wcnt_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wcnt_d  = 3'(RES_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wcnt_q == 3'd1) begin
          res_d       = r_in;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      default: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
    if (pop) begin
      {data_d, sc_d, amt_d} = head;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      sc_q        <= '0;
      amt_q       <= '0;
      wcnt_q      <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sc_q        <= sc_d;
      amt_q       <= amt_d;
      wcnt_q      <= wcnt_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign load      = (state_q == ST_ISSUE);
  assign sc        = load ? sc_q : 2'b00;
  assign data_out  = data_q;
  assign amt       = amt_q;
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural barrel stage driving r_in.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [1:0] cmd_sc;
  logic [2:0] cmd_amt;
  logic       load;
  logic [7:0] data_out;
  logic [1:0] sc;
  logic [2:0] amt;
  logic [7:0] r_in;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sc;
    logic [2:0] amt;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] ord_exp [4];
  int         fill_cnt [5];

  shift_sequencer #(.WIDTH(8), .DEPTH(4), .RES_LAT(1)) dut (
    .clk       (clk),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_sc    (cmd_sc),
    .cmd_amt   (cmd_amt),
    .load      (load),
    .data_out  (data_out),
    .sc        (sc),
    .amt       (amt),
    .r_in      (r_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] barrel(input logic [7:0] d, input logic [1:0] s, input logic [2:0] a);
    logic [15:0] dd;
    dd = {d, d} >> a;
    case (s)
      SC_LSL:  return d << a;
      SC_LSR:  return d >> a;
      SC_ASR:  return 8'($signed(d) >>> a);
      default: return dd[7:0];
    endcase
  endfunction

  // Barrel stage model: latches its result while load is high.
  always @(negedge clk) begin
    if (load) r_in = barrel(data_out, sc, amt);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d, input logic [1:0] s, input logic [2:0] a);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_sc    = s;
    cmd_amt   = a;
  endtask

  initial begin
    int n, k_load, k_res;
    logic [7:0] held;

    vecs[0] = '{8'hA5, SC_ASR, 3'd3, 8'hF4};
    vecs[1] = '{8'hA5, SC_LSL, 3'd1, 8'h4A};
    vecs[2] = '{8'h3C, SC_LSR, 3'd2, 8'h0F};
    vecs[3] = '{8'h81, SC_ROR, 3'd1, 8'hC0};
    vecs[4] = '{8'h80, SC_ASR, 3'd7, 8'hFF};
    vecs[5] = '{8'h0F, SC_LSL, 3'd0, 8'h0F};
    vecs[6] = '{8'h96, SC_ROR, 3'd4, 8'h69};
    ord_exp  = '{8'hC3, 8'hE1, 8'hF0, 8'h78};
    fill_cnt = '{1, 1, 2, 3, 4};

    clear = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_sc = '0; cmd_amt = '0;
    res_ready = 1'b1; r_in = '0;

    // Reset state while clear is held
    #3;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_res_valid", res_valid, 0);
    tick(); tick();
    clear = 1'b0;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1);

    // Single commands through the full handshake, res_ready high
    for (int i = 0; i < 7; i++) begin
      offer(vecs[i].data, vecs[i].sc, vecs[i].amt);
      tick();                                  // E0 push
      cmd_valid = 1'b0;
      chk("v_e0_count", count, 1);
      chk("v_e0_load", load, 0);
      tick();                                  // E1
      chk("v_e1_load", load, 1);
      chk("v_e1_data", data_out, vecs[i].data);
      chk("v_e1_sc", sc, vecs[i].sc);
      chk("v_e1_amt", amt, vecs[i].amt);
      chk("v_e1_count", count, 0);
      tick();                                  // E2
      chk("v_e2_load", load, 0);
      chk("v_e2_sc", sc, 0);
      chk("v_e2_data_hold", data_out, vecs[i].data);
      chk("v_e2_res_valid", res_valid, 0);
      tick();                                  // E3
      chk("v_e3_res_valid", res_valid, 1);
      chk("v_e3_res_data", res_data, vecs[i].exp);
      tick();                                  // E4
      chk("v_e4_res_valid", res_valid, 0);
      chk("v_e4_busy", busy, 0);
    end

    // Backpressure in HOLD with the queue still accepting, then ordered drain
    res_ready = 1'b0;
    offer(8'h5A, SC_LSR, 3'd1);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 10) begin tick(); n++; end
    chk("b_res_valid_seen", res_valid, 1);
    held = res_data;
    chk("b_res_data", held, 8'h2D);
    for (int i = 0; i < 10; i++) begin
      if (i < 4) offer(8'hC3, SC_ROR, 3'(i));
      tick();
      cmd_valid = 1'b0;
      if (i < 4) chk("b_count", count, i + 1);
      chk("b_hold_valid", res_valid, 1);
      chk("b_hold_data", res_data, 8'h2D);
      chk("b_no_load", load, 0);
    end
    chk("b_full_ready", cmd_ready, 0);
    res_ready = 1'b1;
    k_load = 0; k_res = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (load) begin
        chk("b_one_in_flight", k_load, k_res);
        if (k_load < 4) begin
          chk("b_load_amt", amt, k_load);
          chk("b_load_data", data_out, 8'hC3);
          chk("b_load_sc", sc, SC_ROR);
        end
        k_load++;
      end
      if (res_valid) begin
        if (k_res < 4) chk("b_res_order", res_data, ord_exp[k_res]);
        k_res++;
      end
    end
    chk("b_loads_total", k_load, 4);
    chk("b_results_total", k_res, 4);
    chk("b_idle", busy, 0);

    // Clear mid-WAIT with two commands still queued
    offer(8'h55, SC_LSL, 3'd5);
    tick();
    offer(8'h66, SC_LSR, 3'd6);
    tick();
    offer(8'h77, SC_ASR, 3'd2);
    tick();
    cmd_valid = 1'b0;
    chk("r_pre_busy", busy, 1);
    chk("r_pre_count", count, 2);
    chk("r_pre_load", load, 0);
    #2 clear = 1'b1;
    #1;
    chk("r_load", load, 0);
    chk("r_sc", sc, 0);
    chk("r_amt", amt, 0);
    chk("r_data_out", data_out, 0);
    chk("r_res_valid", res_valid, 0);
    chk("r_res_data", res_data, 0);
    chk("r_busy", busy, 0);
    chk("r_cmd_ready", cmd_ready, 0);
    chk("r_count", count, 0);
    tick(); tick();
    clear = 1'b0;
    #1;
    chk("r_rel_count", count, 0);
    chk("r_rel_ready", cmd_ready, 1);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("r_no_load", load, 0);
      chk("r_no_result", res_valid, 0);
    end

    // Fill: five back-to-back commands against a stalled consumer
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(8'h10 + 8'(i), SC_LSL, 3'd1);
      chk("f_ready_before_push", cmd_ready, 1);
      tick();
      chk("f_count", count, fill_cnt[i]);
    end
    offer(8'hEE, SC_LSL, 3'd1);
    chk("f_full_ready", cmd_ready, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("f_count_capped", count, 4);
      chk("f_ready_low", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, data width of shift operands and results.
REQ-002 Parameter DEPTH, default 4, command queue entries; SHALL be a power of two, at least 2.
REQ-003 Parameter RES_LAT, default 1, cycles between load pulse end and result capture; SHALL be 1..7.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 clear  in  1  reset: asynchronous, active-high.
REQ-006 cmd_valid  in  1  upstream command offered.
REQ-007 cmd_ready  out  1  queue can accept a command.
REQ-008 cmd_data  in  WIDTH  operand to shift.
REQ-009 cmd_sc  in  2  shift-type code.
REQ-010 cmd_amt  in  3  shift amount 0..7.
REQ-011 load  out  1  one-cycle load strobe to barrel register stage.
REQ-012 data_out  out  WIDTH  operand to barrel stage.
REQ-013 sc  out  2  shift type to barrel stage.
REQ-014 amt  out  3  shift amount to barrel stage.
REQ-015 r_in  in  WIDTH  result R returned by barrel stage.
REQ-016 res_valid  out  1  captured result available.
REQ-017 res_ready  in  1  downstream accepts result.
REQ-018 res_data  out  WIDTH  captured result.
REQ-019 busy  out  1  FSM not in IDLE.
REQ-020 count  out  log2(DEPTH)+1  queue occupancy.

Function
REQ-021 Push SHALL occur on an edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL equal (count != DEPTH).
REQ-022 Queue SHALL be FIFO-ordered, with wrap-around pointers; push while full SHALL be impossible, and pop while empty SHALL never occur.
REQ-023 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-024 IDLE: if count > 0, SHALL pop the head, register it onto data_out/sc/amt, and go to ISSUE; otherwise remain.
REQ-025 ISSUE: load SHALL be 1 for exactly this one cycle; next state SHALL be WAIT with the wait counter equal to RES_LAT.
REQ-026 WAIT: counter SHALL decrement each cycle; on the edge it reaches 1, r_in SHALL be captured into res_data, res_valid SHALL be set, and state SHALL become HOLD.
REQ-027 HOLD: res_valid and res_data SHALL stay stable until res_ready is high.
REQ-028 On that res_ready edge res_valid SHALL drop, and the FSM SHALL go to ISSUE, popping the next head, if count > 0; otherwise it SHALL go to IDLE.
REQ-029 Outside ISSUE, load SHALL be 0 and sc SHALL be 2'b00; data_out and amt SHALL hold their last value.
REQ-030 Latency into an empty queue, RES_LAT=1: push at edge E0; load high E1–E2; res_valid high from E3.
REQ-031 A push and a pop on the same edge SHALL leave count unchanged.
REQ-032 A push into an empty queue SHALL NOT be popped on its push edge.
REQ-033 A push while the FSM is in HOLD SHALL be queued and not disturb res_data.
REQ-034 At most one command SHALL be in flight at once.

Reset
REQ-035 While clear is high, and immediately on assertion, the block SHALL be forced to: state IDLE, queue empty, count 0, load 0, sc 0, amt 0, data_out 0, res_valid 0, res_data 0, busy 0, cmd_ready 0.
REQ-036 After clear is released, cmd_ready SHALL be 1.
REQ-037 clear mid-operation SHALL discard queued and in-flight commands; no result SHALL be produced for them.

Structure
REQ-038 Shared package shift_pkg SHALL hold the shift-type code constants and the FSM state encoding.
REQ-039 The queue SHALL be one sub-module, shift_cmd_fifo, storing {data, sc, amt} per entry and providing push, pop, full, empty and count.

Verification
REQ-040 Reset: assert clear mid-WAIT with 2 commands queued -> all outputs 0 at once; after release count=0, cmd_ready=1, no load.
REQ-041 Single command: push data=8'hA5, sc=2, amt=3, res_ready=1, r_in model-driven -> load high for 1 cycle with data_out=8'hA5, sc=2, amt=3; res_valid from E3 with res_data equal to model.
REQ-042 Fill: push 5 back-to-back commands with DEPTH=4 and res_ready=0 -> cmd_ready low once 4 are held.
REQ-043 Fill, continued: 5th command accepted only after first pop; count never exceeds 4.
REQ-044 Backpressure: hold res_ready=0 for 10 cycles in HOLD -> res_data stable; no second load issued; queue continues accepting.
REQ-045 Ordering: push 4 commands, amt=0..3, then release res_ready -> loads in push order, one per result handshake; results in order.
